// File: rtl/serial_operand_receiver_if.sv
// Operand hand-off bus between the serial receiver and the operand controller.
// The receiver takes the slave side; the controller (or a bench) the master.
interface serial_operand_receiver_if #(
    parameter int DATA_W = 8,
    parameter int NWORDS = 2
);
    logic                       rx;
    logic                       load;
    logic                       flush;
    logic                       controller_inuse;
    logic                       ready;
    logic                       error;
    logic                       rx_busy;
    logic [NWORDS*DATA_W-1:0]   operand;

    modport slave (
        input  rx, load, flush, controller_inuse,
        output ready, error, rx_busy, operand
    );

    modport master (
        output rx, load, flush, controller_inuse,
        input  ready, error, rx_busy, operand
    );
endinterface

// File: rtl/serial_operand_receiver.sv
// Serial front end: deserialises parity-framed words from rx, packs NWORDS
// of them into one operand and offers it to the controller via ready/load.
module serial_operand_receiver #(
    parameter int DATA_W       = 8,
    parameter int NWORDS       = 2,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_operand_receiver_if.slave bus
);
    localparam int OP_W  = NWORDS * DATA_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WC_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t            state;
    state_t            next;
    logic              sync1;
    logic              rxs;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_ok;
    logic [WC_W-1:0]   word_cnt;
    logic [OP_W-1:0]   asm_reg;
    logic [OP_W-1:0]   asm_nxt;
    logic [OP_W-1:0]   op;
    logic              rdy;
    logic              err;

    logic tick;
    logic last_bit;
    logic samp_data;
    logic samp_par;
    logic stop_edge;
    logic commit;
    logic fault;
    logic last_word;
    logic take;
    logic overrun;

    assign bus.ready   = rdy;
    assign bus.error   = err;
    assign bus.operand = op;

    // Two-flop synchroniser; idles high so reset never looks like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rxs   <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Next state; a start is rxs about to fall, so a line held low
    // after a flush cannot start a frame until it has been high again.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (!sync1 && rxs) next = START;
            START:   if (tick) next = rxs ? IDLE : DATA;
            DATA:    if (tick && last_bit) next = PARITY;
            PARITY:  if (tick) next = STOP;
            STOP:    if (tick) next = IDLE;
            default: next = IDLE;
        endcase
        if (bus.flush) next = IDLE;
    end

    // FSM outputs: sample strobes and the word/operand commit decisions.
    always_comb begin
        bus.rx_busy = (state != IDLE);
        tick        = (state == START) ? (cnt == HALF) : (cnt == FULL);
        last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
        samp_data   = (state == DATA) && tick;
        samp_par    = (state == PARITY) && tick;
        stop_edge   = (state == STOP) && tick;
        commit      = stop_edge && par_ok && rxs;
        fault       = stop_edge && !(par_ok && rxs);
        last_word   = (word_cnt == WC_W'(NWORDS - 1));
        take        = commit && last_word && (!rdy || bus.load);
        overrun     = commit && last_word && rdy && !bus.load;
        asm_nxt     = asm_reg;
        asm_nxt[int'(word_cnt) * DATA_W +: DATA_W] = shreg;
    end

    // Bit timing, data shift register and parity capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
        end else begin
            if (state == IDLE || tick || bus.flush) cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
            if (state == START)  bit_cnt <= '0;
            else if (samp_data)  bit_cnt <= bit_cnt + 1'b1;
            if (samp_data) shreg  <= {rxs, shreg[DATA_W-1:1]};
            if (samp_par)  par_ok <= ~(^shreg ^ rxs);
        end
    end

    // Word assembly, operand hand-off and sticky error; flush wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy      <= 1'b0;
            err      <= 1'b0;
            op       <= '0;
            asm_reg  <= '0;
            word_cnt <= '0;
        end else if (bus.flush) begin
            rdy      <= 1'b0;
            err      <= 1'b0;
            op       <= '0;
            asm_reg  <= '0;
            word_cnt <= '0;
        end else begin
            if (take) begin
                rdy <= 1'b1;
                op  <= asm_nxt;
            end else if (bus.load) begin
                rdy <= 1'b0;
            end
            if (fault || overrun)           err <= 1'b1;
            else if (!bus.controller_inuse) err <= 1'b0;
            if (fault)       word_cnt <= '0;
            else if (commit) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            if (commit) asm_reg <= asm_nxt;
        end
    end
endmodule

// File: tb/tb_serial_operand_receiver.sv
// Randomised self-checking bench for serial_operand_receiver against
// a frame-level model of the operand hand-off rules.
module tb_serial_operand_receiver;
    localparam int DATA_W = 8;
    localparam int NWORDS = 2;
    localparam int CPB    = 4;
    localparam int OFS    = 2 + CPB / 2;
    localparam int OP_W   = DATA_W * NWORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_operand_receiver_if #(.DATA_W(DATA_W), .NWORDS(NWORDS)) bus();

    serial_operand_receiver #(
        .DATA_W(DATA_W), .NWORDS(NWORDS), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vec = 0;
    int bad = 0;

    bit              m_ready;
    bit              m_err;
    int              m_cnt;
    logic [DATA_W-1:0] m_asm [NWORDS];
    logic [OP_W-1:0] m_op;

    logic [OP_W+2:0] obs;
    logic [OP_W+2:0] exp_v;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_ready = 0;
        m_err   = 0;
        m_cnt   = 0;
        m_op    = '0;
        for (int i = 0; i < NWORDS; i++) m_asm[i] = '0;
    endtask

    task automatic snap();
        obs   = {bus.ready, bus.error, bus.rx_busy, bus.operand};
        exp_v = {m_ready, m_err, 1'b0, m_op};
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input bit bp,
                              input bit bs, input bit ld);
        logic [DATA_W+2:0] bits;
        bits = {~bs, (^d) ^ bp, d, 1'b0};
        for (int i = 0; i < DATA_W + 2; i++) begin
            bus.rx = bits[i];
            step(CPB);
        end
        bus.rx = bits[DATA_W+2];
        step(OFS - 1);
        bus.load = ld;
        step(1);
        bus.load = 1'b0;
        step(CPB - OFS);
        if (bs) begin
            bus.rx = 1'b1;
            step(2 * CPB);
        end
    endtask

    task automatic model_frame(input logic [DATA_W-1:0] d, input bit bp,
                               input bit bs, input bit ld);
        bit took;
        took = 0;
        if (bp || bs) begin
            m_err = 1;
            m_cnt = 0;
        end else begin
            m_asm[m_cnt] = d;
            if (m_cnt < NWORDS - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                if (!m_ready || ld) begin
                    for (int i = 0; i < NWORDS; i++)
                        m_op[i*DATA_W +: DATA_W] = m_asm[i];
                    m_ready = 1;
                    took = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        if (ld && !took) m_ready = 0;
    endtask

    task automatic frame(input logic [DATA_W-1:0] d, input bit bp,
                         input bit bs, input bit ld);
        send_frame(d, bp, bs, ld);
        model_frame(d, bp, bs, ld);
    endtask

    task automatic pulse_load();
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        m_ready = 0;
    endtask

    task automatic clear_err();
        bus.controller_inuse = 1'b0;
        step(1);
        bus.controller_inuse = 1'b1;
        m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rx = 1'b1;
        bus.load = 1'b0;
        bus.flush = 1'b0;
        bus.controller_inuse = 1'b1;
        model_clear();
        #2;
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs, exp_v);
        end
        step(3);
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        frame(8'hA5, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL basic_word0: got %h want %h", obs, exp_v);
        end
        frame(8'h3C, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h3CA5) begin
            bad++;
            $display("FAIL basic_operand: got %h want %h", obs, exp_v);
        end
        pulse_load();
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h3CA5) begin
            bad++;
            $display("FAIL basic_load: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_parity();
        frame(8'h77, 0, 0, 0);
        frame(8'h01, 1, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.error !== 1'b1) begin
            bad++;
            $display("FAIL parity_err: got %h want %h", obs, exp_v);
        end
        step(10);
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL parity_sticky: got %h want %h", obs, exp_v);
        end
        clear_err();
        snap();
        vec++;
        if (obs !== exp_v || bus.error !== 1'b0) begin
            bad++;
            $display("FAIL parity_clear: got %h want %h", obs, exp_v);
        end
        frame(8'h11, 0, 0, 0);
        frame(8'h22, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h2211) begin
            bad++;
            $display("FAIL parity_drop: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_stop();
        frame(8'h44, 0, 0, 0);
        frame(8'h55, 0, 1, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL stop_err: got %h want %h", obs, exp_v);
        end
        clear_err();
        pulse_load();
        frame(8'h66, 0, 0, 0);
        frame(8'h99, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h9966) begin
            bad++;
            $display("FAIL stop_cnt: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_overrun();
        pulse_load();
        frame(8'hA5, 0, 0, 0);
        frame(8'h3C, 0, 0, 0);
        frame(8'h0F, 0, 0, 0);
        frame(8'hF0, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h3CA5) begin
            bad++;
            $display("FAIL overrun: got %h want %h", obs, exp_v);
        end
        pulse_load();
        clear_err();
        frame(8'hA5, 0, 0, 0);
        frame(8'h3C, 0, 0, 0);
        frame(8'h0F, 0, 0, 0);
        frame(8'hF0, 0, 0, 1);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'hF00F) begin
            bad++;
            $display("FAIL load_at_stop: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_false_start();
        bus.rx = 1'b0;
        step(1);
        bus.rx = 1'b1;
        step(10);
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL false_start: got %h want %h", obs, exp_v);
        end
        pulse_load();
        frame(8'h12, 0, 0, 0);
        frame(8'h34, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h3412) begin
            bad++;
            $display("FAIL false_start_cnt: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_flush();
        frame(8'h0E, 1, 0, 0);
        frame(8'hAB, 0, 0, 0);
        bus.rx = 1'b0;
        step(3 * CPB);
        vec++;
        if (bus.rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_busy: got %b want 1", bus.rx_busy);
        end
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        model_clear();
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL flush: got %h want %h", obs, exp_v);
        end
        step(20);
        vec++;
        if (bus.rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_low: got %b want 0", bus.rx_busy);
        end
        bus.rx = 1'b1;
        step(2 * CPB);
        frame(8'hCD, 0, 0, 0);
        frame(8'hEF, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'hEFCD) begin
            bad++;
            $display("FAIL flush_after: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        frame(8'h5A, 0, 0, 0);
        bus.rx = 1'b0;
        step(3 * CPB);
        rst = 1'b0;
        #1;
        model_clear();
        snap();
        vec++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", obs, exp_v);
        end
        bus.rx = 1'b1;
        step(2);
        rst = 1'b1;
        step(2 * CPB);
        frame(8'h81, 0, 0, 0);
        frame(8'h7E, 0, 0, 0);
        snap();
        vec++;
        if (obs !== exp_v || bus.operand !== 16'h7E81) begin
            bad++;
            $display("FAIL reset_after: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        bit bp, bs, ld;
        for (int n = 0; n < 40; n++) begin
            d  = DATA_W'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = !bp && ($urandom_range(0, 7) == 0);
            ld = ($urandom_range(0, 3) == 0);
            frame(d, bp, bs, ld);
            snap();
            vec++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random_%0d: got %h want %h", n, obs, exp_v);
            end
            if ($urandom_range(0, 3) == 0) pulse_load();
            if ($urandom_range(0, 4) == 0) clear_err();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_overrun();
        test_false_start();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/serial_operand_receiver.md
Name: serial_operand_receiver

Overview:
Serial front end that feeds the operand controller. It deserialises framed words from a single-bit line, checks parity and stop bits, and packs NWORDS words into one operand. It then presents the operand with a ready/load handshake: it drives ready and error into the controller and consumes the controller's load, flush and controller_inuse.

Parameters:
DATA_W, 8, data bits per serial word
NWORDS, 2, words per operand
CLKS_PER_BIT, 4, clk cycles per serial bit (even, >=4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
rx  input  1  serial line; idles high
load  input  1  controller consumes the current operand
flush  input  1  controller abort; clears receiver state
controller_inuse  input  1  controller is out of IDLE
ready  output  1  operand register holds an unconsumed operand
error  output  1  fault flag (parity, stop bit or overrun)
operand  output  NWORDS*DATA_W  assembled operand; word 0 in the LSBs
rx_busy  output  1  frame reception in progress

Behaviour:
- Reset (rst=0, asynchronous): ready=0, error=0, operand=0, rx_busy=0, FSM=IDLE, word_cnt=0, both synchroniser flops=1.
- rx passes through a 2-flop synchroniser. All sampling below uses the synchronised value rxs.
- Frame format: 1 start bit (0), DATA_W data bits LSB first, 1 even-parity bit (ones in data+parity even), 1 stop bit (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on rxs moves to START, clears the bit counter, sets rx_busy=1.
  - START: waits CLKS_PER_BIT/2 cycles to mid-bit. If rxs=1 it is a false start: back to IDLE, no error.
  - DATA: samples every CLKS_PER_BIT cycles, shifting right into the word register. After DATA_W samples it moves to PARITY.
  - PARITY: samples once and records the parity result.
  - STOP: samples once, then returns to IDLE with rx_busy=0 on the same edge. There is no wait for the end of the stop bit, so back-to-back frames are accepted.
- Word commit, at the stop-sample edge, when parity and stop are both good:
  - The word is written to assembly slot word_cnt, bits [word_cnt*DATA_W +: DATA_W].
  - If word_cnt<NWORDS-1, word_cnt increments.
  - If word_cnt==NWORDS-1, word_cnt wraps to 0 and the assembled value is offered to the output register.
- Output transfer, on that same edge:
  - If ready=0, or load=1 this cycle: operand<=assembly and ready<=1.
  - Otherwise it is an overrun: error<=1, the new operand is discarded, and operand/ready keep their values.
- Load handshake:
  - load=1 with ready=1 clears ready on the next edge; operand keeps its value.
  - load=1 with ready=0 is ignored.
  - A simultaneous load and new-operand transfer leaves ready=1 with the new value.
- Faults:
  - A parity mismatch or stop bit=0 at the stop-sample edge sets error=1, discards the word, and resets word_cnt to 0, dropping the partial operand. ready and operand are unchanged.
  - error is sticky while controller_inuse=1. It clears on the first edge with controller_inuse=0 and no new fault that cycle.
  - A new fault in the same cycle keeps error=1.
- flush=1 has priority over every other event on that edge: ready=0, error=0, operand=0, word_cnt=0, FSM=IDLE, rx_busy=0. A frame in flight is abandoned, and a line still low is not treated as a new start until rxs returns high.
- Reset mid-frame behaves as in reset; no partial state survives.
- Latency: the rx transition reaches the FSM after 2 clk. ready rises at the edge that samples the final word's valid stop bit.

Test Plan:
- Defaults. Send frame 0xA5 (parity 0, stop 1), then 0x3C (parity 0) -> ready=1, operand=0x3CA5 at the second stop sample. Pulse load one cycle -> ready=0 next edge, operand stays 0x3CA5.
- Send 0x01 with parity bit 0, controller_inuse=1 -> error=1 and held. Drop controller_inuse -> error=0 next edge. Then send 0x11, 0x22 -> operand=0x2211 (the earlier partial was dropped).
- Send 0x55 with stop bit 0 -> error=1, ready unchanged, word_cnt=0.
- Send 0xA5, 0x3C, 0x0F, 0xF0 with no load -> first operand 0x3CA5 retained, error=1 on the fourth stop sample, ready stays 1. Repeat with load asserted on the fourth stop-sample edge -> operand=0xF00F, ready=1, no error.
- rx low for 1 clk, then high -> no state change, rx_busy=0, no error.
- Assert flush mid-DATA of word 1 -> ready=0, error=0, operand=0, rx_busy=0 next edge. Hold rx low afterwards -> no start until rx returns high. Separately, assert rst=0 mid-frame -> all outputs 0 immediately.
